bus_xfer_ctrl: RTL
==================

# bus_xfer_ctrl

Sequencer that owns the control side of the shared internal data bus: it drives the per-register `output_enable` and `load` strobes of the bus registers to move one register's contents into one or more other registers. It accepts a transfer request from the CPU control unit. It enables exactly one source onto the bus, waits a programmable settle time, strobes the destination loads, and samples the bus value. It sits between the instruction decoder/control unit and the bank of n-bit bus registers.

## Interface
- `N_REG`, 8, number of bus registers (indices 0..N_REG-1)
- `W`, 8, bus data width
- `SETTLE`, 1, DRIVE cycles before the LATCH cycle (0..15)
- `SW`, $clog2(N_REG), source index width (derived)

Ports:
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `req_valid` input 1: transfer request valid
- `req_ready` output 1: controller can accept a request
- `req_src` input SW: source register index
- `req_dst` input N_REG: destination mask (bit i loads register i)
- `bus_in` input W: observed value of the shared bus
- `output_enable` output N_REG: one-hot or zero source enables
- `load` output N_REG: destination load strobes
- `done` output 1: one-cycle completion pulse
- `error` output 1: valid only with `done`; request was rejected
- `done_data` output W: bus value captured on the last successful transfer

## Operation
- States: IDLE, DRIVE, LATCH.
- IDLE:
  - `req_ready`=1; the handshake is `req_valid && req_ready` at a rising edge.
  - On accept, the controller registers `req_src` and `req_dst` and checks legality.
- Illegal request, which goes to IDLE with no strobes:
  - `req_src >= N_REG`, or
  - `req_dst == 0`, or
  - `req_dst[req_src]==1` (self-load).
  - `done`=1 and `error`=1 next cycle; `done_data` unchanged.
- Legal request:
  - If SETTLE>0, go to DRIVE with the settle counter loaded to SETTLE-1.
  - If SETTLE=0, go directly to LATCH.
- DRIVE:
  - `output_enable[src]`=1, `load`=0.
  - The counter decrements each cycle; at 0, go to LATCH.
- LATCH:
  - `output_enable[src]`=1 and `load`=dst mask for exactly one cycle.
  - At the closing edge, capture `bus_in` into `done_data` and go to IDLE.
  - `done`=1 and `error`=0 in the following cycle.
- `output_enable`, `load`, `done`, `error` and `req_ready` are decoded from registered state only; there is no combinational path from `req_*` to any output.
- `output_enable` is never asserted on more than one bit. `load` is asserted only while `output_enable` is nonzero.
- `req_valid` outside IDLE is ignored. The request is not stored; the requester holds it until `req_ready`.

## Timing
- Reset (asynchronous, immediate on `rst_n`=0):
  - state IDLE, counter 0.
  - `output_enable`=0, `load`=0, `done`=0, `error`=0, `done_data`=0.
  - `req_ready`=0 while `rst_n`=0; 1 from the first cycle after release.
- Legal transfer accepted at edge E0:
  - DRIVE in cycles E0+1 .. E0+SETTLE.
  - LATCH in cycle E0+SETTLE+1.
  - `done` in cycle E0+SETTLE+2, which is also IDLE with `req_ready`=1.
- Back-to-back legal transfers issue every SETTLE+2 cycles. A request can be accepted in the same cycle that `done` is high.
- Illegal request: `done`/`error` one cycle after acceptance. `req_ready`=1 in that cycle.
- Reset mid-transfer (DRIVE or LATCH):
  - Strobes drop asynchronously; no `done` pulse is generated.
  - `done_data` clears to 0.
- `bus_in` is sampled only at the LATCH closing edge; any Z/X at other times has no effect.

## Test plan
- Reset release, SETTLE=1: request src=2, dst=8'b0001_0000, `bus_in`=8'hA5.
  - Cycle+1: `output_enable`=8'b0000_0100, `load`=0.
  - Cycle+2: `load`=8'b0001_0000.
  - Cycle+3: `done`=1, `error`=0, `done_data`=8'hA5.
- Multi-destination: src=0, dst=8'b1000_0110 → a single LATCH cycle with `load`=8'b1000_0110, `output_enable`=8'b0000_0001.
- Illegal requests, each giving no strobes and `done`=`error`=1 one cycle after acceptance:
  - src=3, dst=8'b0000_1000 (self-load);
  - dst=0;
  - src=7 with N_REG=6.
- Handshake: hold `req_valid`=1 with a new request throughout a transfer.
  - The second request is accepted only in the `done` cycle.
  - `output_enable` never shows two bits set.
- SETTLE=0 and SETTLE=3 builds:
  - DRIVE cycle count is 0 and 3 respectively.
  - `done` occurs 2 and 5 cycles after acceptance.
- Assert `rst_n`=0 during LATCH:
  - `load` and `output_enable` go 0 the same cycle without waiting for a clock edge.
  - No `done` pulse; `done_data`=0.
  - After release, a fresh transfer completes normally.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_ctrl
// Purpose  : Sequences one register-to-register move on the shared data bus:
//            enable one source, settle, strobe destination loads, capture.
// Revision : 1.0
// ============================================================================
module bus_xfer_ctrl #(
    parameter int N_REG  = 8,
    parameter int W      = 8,
    parameter int SETTLE = 1,
    parameter int SW     = $clog2(N_REG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SW-1:0]    req_src,
    input  logic [N_REG-1:0] req_dst,
    input  logic [W-1:0]     bus_in,
    output logic [N_REG-1:0] output_enable,
    output logic [N_REG-1:0] load,
    output logic             done,
    output logic             error,
    output logic [W-1:0]     done_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_next;
    logic [SW-1:0]    r_src;
    logic [N_REG-1:0] r_dst;
    logic             r_done;
    logic             r_err;
    logic             w_done_next;
    logic             w_err_next;
    logic [W-1:0]     r_data;
    logic             r_alive;

    logic             w_accept;
    logic             w_src_ok;
    logic             w_self;
    logic             w_legal;
    logic [2**SW-1:0] w_dst_pad;

    // Index range of req_src may exceed N_REG when N_REG is not a power of two
    generate
        if (2**SW == N_REG) begin : g_src_full
            assign w_src_ok = 1'b1;
        end else begin : g_src_cmp
            assign w_src_ok = (req_src < SW'(N_REG));
        end
    endgenerate

    assign w_dst_pad = (2**SW)'(req_dst);
    assign w_self    = w_dst_pad[req_src];
    assign w_legal   = w_src_ok && (|req_dst) && !w_self;

    assign req_ready = r_alive && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_src   <= '0;
            r_dst   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            if (w_accept) begin
                r_src <= req_src;
                r_dst <= req_dst;
            end
            if (r_state == S_LATCH) begin
                r_data <= bus_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end else if (SETTLE == 0) begin
                        w_state_next = S_LATCH;
                    end else begin
                        w_state_next = S_DRIVE;
                        w_cnt_next   = C_SETTLE_LOAD;
                    end
                end
            end
            S_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_LATCH;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_LATCH: begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Strobes depend only on registered state, so reset removes them at once
    always_comb begin
        output_enable = '0;
        load          = '0;
        for (int i = 0; i < N_REG; i++) begin
            output_enable[i] = (r_state != S_IDLE) && (r_src == SW'(i));
        end
        if (r_state == S_LATCH) begin
            load = r_dst;
        end
    end

    assign done      = r_done;
    assign error     = r_err;
    assign done_data = r_data;

endmodule
`default_nettype wire
